usb_tx_sequencer: RTL and testbench

//  Sequences and arbitrates the shared low-speed USB transmit line between two requesters:

---
 rtl/usb_tx_pkg.sv | 34 +++
 rtl/usb_tx_sequencer_if.sv | 29 ++
 rtl/usb_crc16_serial.sv | 26 ++
 rtl/usb_tx_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared constants, state encoding and CRC helper for the low-speed USB transmit sequencer.
package usb_tx_pkg;

  localparam int unsigned PID_W = 8;
  localparam int unsigned LEN_W = 4;

  localparam logic [PID_W-1:0] PID_ACK   = 8'hD2;
  localparam logic [PID_W-1:0] PID_DATA0 = 8'hC3;
  localparam logic [PID_W-1:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0]       SYNC_BYTE = 8'h80;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Fields go out LSB first, so the serial CRC runs in reflected form.
  localparam logic [15:0] CRC16_POLY_REFL = reflect16(CRC16_POLY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Request/descriptor side and per-bit line controls between requesters, sequencer and NRZI encoder.
interface usb_tx_sequencer_if;
  import usb_tx_pkg::*;

  logic             bitTick;
  logic             reqAck;
  logic             reqDesc;
  logic [PID_W-1:0] descPid;
  logic [LEN_W-1:0] descLen;
  logic [7:0]       descByte;
  logic             descRd;
  logic             grantAck;
  logic             grantDesc;
  logic             doneAck;
  logic             doneDesc;
  logic             txOE;
  logic             txData;
  logic             txEop;

  modport master (
    output bitTick, reqAck, reqDesc, descPid, descLen, descByte,
    input  descRd, grantAck, grantDesc, doneAck, doneDesc, txOE, txData, txEop
  );

  modport slave (
    input  bitTick, reqAck, reqDesc, descPid, descLen, descByte,
    output descRd, grantAck, grantDesc, doneAck, doneDesc, txOE, txData, txEop
  );
endinterface

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 over LSB-first data; holds the running remainder in reflected form.
module usb_crc16_serial
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = din ^ r_crc[0];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_crc <= CRC16_INIT;
    end else if (en) begin
      r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16_POLY_REFL : 16'h0000);
    end
  end

  assign crc = r_crc;
endmodule

// File: rtl/usb_tx_sequencer.sv
// Arbitrates ACK vs descriptor packets onto the low-speed USB line and emits per-bit
// SYNC/PID/payload/CRC16/EOP controls with bit stuffing for the NRZI encoder.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter logic [PID_W-1:0] ACK_PID      = PID_ACK,
  parameter int unsigned      MAX_LEN      = 8,
  parameter int unsigned      EOP_SE0_BITS = 2,
  parameter int unsigned      GAP_BITS     = 2
) (
  input logic               useClk,
  input logic               rst,
  usb_tx_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = 5;

  tx_state_e        r_state;
  logic             r_isDesc;
  logic             r_grantAck;
  logic             r_grantDesc;
  logic             r_doneAck;
  logic             r_doneDesc;
  logic             r_descRd;
  logic             r_txOE;
  logic             r_txData;
  logic             r_txEop;
  logic [PID_W-1:0] r_pid;
  logic [15:0]      r_shift;
  logic [CNT_W-1:0] r_bitCnt;
  logic [LEN_W-1:0] r_bytesLeft;
  logic [2:0]       r_ones;

  logic             w_inField;
  logic             w_fieldEnd;
  logic             w_byteField;
  logic             w_stuff;
  logic             w_toPid;
  logic             w_toData;
  logic             w_toCrc;
  logic             w_toEop;
  logic             w_payload;
  logic             w_bit;
  logic             w_crcClr;
  logic [15:0]      w_load;
  logic [15:0]      w_crc;
  logic [LEN_W-1:0] w_len;

  // r_bitCnt counts bits already sent of the field in r_shift; at field end the next field's
  // first bit goes out on the same tick it is loaded.
  assign w_inField   = (r_state == ST_SYNC) || (r_state == ST_PID) ||
                       (r_state == ST_DATA) || (r_state == ST_CRC);
  assign w_fieldEnd  = (r_bitCnt == ((r_state == ST_CRC) ? CNT_W'(16) : CNT_W'(8)));
  assign w_stuff     = w_inField && (r_ones == 3'd6);
  assign w_byteField = ((r_state == ST_PID) && r_isDesc) || (r_state == ST_DATA);
  assign w_toPid     = w_fieldEnd && (r_state == ST_SYNC);
  assign w_toData    = w_fieldEnd && w_byteField && (r_bytesLeft != '0);
  assign w_toCrc     = w_fieldEnd && w_byteField && (r_bytesLeft == '0);
  assign w_toEop     = w_fieldEnd && (((r_state == ST_PID) && !r_isDesc) || (r_state == ST_CRC));
  assign w_load      = w_toData ? {8'h00, bus.descByte} : (w_toCrc ? ~w_crc : {8'h00, r_pid});
  assign w_bit       = w_fieldEnd ? w_load[0] : r_shift[0];
  assign w_payload   = !w_stuff && (w_toData || ((r_state == ST_DATA) && !w_fieldEnd));
  assign w_len       = (32'(bus.descLen) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.descLen;
  assign w_crcClr    = bus.bitTick && (r_state == ST_IDLE);

  usb_crc16_serial u_crc (
    .clk (useClk),
    .rst (rst),
    .clr (w_crcClr),
    .en  (bus.bitTick && w_payload),
    .din (w_bit),
    .crc (w_crc)
  );

  always_ff @(posedge useClk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_isDesc    <= 1'b0;
      r_grantAck  <= 1'b0;
      r_grantDesc <= 1'b0;
      r_doneAck   <= 1'b0;
      r_doneDesc  <= 1'b0;
      r_descRd    <= 1'b0;
      r_txOE      <= 1'b0;
      r_txData    <= 1'b0;
      r_txEop     <= 1'b0;
      r_pid       <= '0;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_bytesLeft <= '0;
      r_ones      <= '0;
    end else begin
      r_descRd   <= 1'b0;
      r_doneAck  <= 1'b0;
      r_doneDesc <= 1'b0;
      if (bus.bitTick) begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.reqAck || bus.reqDesc) begin
              r_isDesc    <= !bus.reqAck;
              r_grantAck  <= bus.reqAck;
              r_grantDesc <= !bus.reqAck;
              r_pid       <= bus.reqAck ? ACK_PID : bus.descPid;
              r_bytesLeft <= bus.reqAck ? '0 : w_len;
              r_txOE      <= 1'b1;
              r_txData    <= SYNC_BYTE[0];
              r_shift     <= 16'(SYNC_BYTE >> 1);
              r_bitCnt    <= CNT_W'(1);
              r_ones      <= '0;
              r_state     <= ST_SYNC;
            end
          end
          ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
            if (w_stuff) begin
              r_txData <= 1'b0;
              r_ones   <= '0;
            end else if (w_toEop) begin
              r_txData <= 1'b0;
              r_txEop  <= 1'b1;
              r_bitCnt <= CNT_W'(1);
              r_ones   <= '0;
              r_state  <= ST_EOP;
            end else begin
              r_txData <= w_bit;
              r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
              if (w_fieldEnd) begin
                r_shift  <= w_load >> 1;
                r_bitCnt <= CNT_W'(1);
                if (w_toData) begin
                  r_bytesLeft <= r_bytesLeft - LEN_W'(1);
                  r_descRd    <= 1'b1;
                  r_state     <= ST_DATA;
                end else if (w_toCrc) begin
                  r_state <= ST_CRC;
                end else if (w_toPid) begin
                  r_state <= ST_PID;
                end
              end else begin
                r_shift  <= r_shift >> 1;
                r_bitCnt <= r_bitCnt + CNT_W'(1);
              end
            end
          end
          ST_EOP: begin
            if (r_bitCnt < CNT_W'(EOP_SE0_BITS)) begin
              r_bitCnt <= r_bitCnt + CNT_W'(1);
            end else if (r_bitCnt == CNT_W'(EOP_SE0_BITS)) begin
              r_txEop  <= 1'b0;
              r_txData <= 1'b1;
              r_bitCnt <= r_bitCnt + CNT_W'(1);
            end else begin
              r_txOE      <= 1'b0;
              r_txData    <= 1'b0;
              r_grantAck  <= 1'b0;
              r_grantDesc <= 1'b0;
              r_doneAck   <= !r_isDesc;
              r_doneDesc  <= r_isDesc;
              r_bitCnt    <= '0;
              r_state     <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (32'(r_bitCnt) + 32'd1 >= GAP_BITS) begin
              r_state <= ST_IDLE;
            end else begin
              r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.descRd    = r_descRd;
  assign bus.grantAck  = r_grantAck;
  assign bus.grantDesc = r_grantDesc;
  assign bus.doneAck   = r_doneAck;
  assign bus.doneDesc  = r_doneDesc;
  assign bus.txOE      = r_txOE;
  assign bus.txData    = r_txData;
  assign bus.txEop     = r_txEop;
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench: per-tick line controls compared against a field/stuffing/CRC model.
module tb_usb_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int EOP_SE0_BITS = 2;
  localparam int GAP_BITS     = 2;
  localparam int MAX_LEN      = 8;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  int         tick_gap = 0;
  logic [7:0] pay [16];

  usb_tx_sequencer_if bus ();

  usb_tx_sequencer #(
    .ACK_PID      (PID_ACK),
    .MAX_LEN      (MAX_LEN),
    .EOP_SE0_BITS (EOP_SE0_BITS),
    .GAP_BITS     (GAP_BITS)
  ) dut (
    .useClk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.txOE, bus.txData, bus.txEop, bus.grantAck, bus.grantDesc, bus.doneAck, bus.doneDesc};
  endfunction

  // CRC-16/USB over whole bytes, result already inverted for transmission.
  function automatic logic [15:0] crc_model(input int nb);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < nb; i++) begin
      c = c ^ {8'h00, pay[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic tick();
    repeat (tick_gap) @(negedge clk);
    bus.bitTick = 1'b1;
    @(negedge clk);
    bus.bitTick = 1'b0;
  endtask

  task automatic drop_req(input bit is_desc);
    if (is_desc) bus.reqDesc = 1'b0;
    else         bus.reqAck  = 1'b0;
  endtask

  task automatic run_pkt(input string name, input bit is_desc, input logic [7:0] pid, input int nb,
                         input int freeze_at, input int rst_at, input bit drop);
    bit         bits [$];
    logic [2:0] exp [$];
    logic [7:0] sync = 8'h80;
    logic [15:0] crc;
    logic [6:0] act;
    logic [6:0] expv;
    int         ones = 0;
    int         rd = 0;
    int         idx = 0;
    int         bad;
    for (int k = 0; k < 8; k++) bits.push_back(sync[k]);
    for (int k = 0; k < 8; k++) bits.push_back(pid[k]);
    if (is_desc) begin
      for (int i = 0; i < nb; i++)
        for (int k = 0; k < 8; k++) bits.push_back(pay[i][k]);
      crc = crc_model(nb);
      for (int k = 0; k < 16; k++) bits.push_back(crc[k]);
    end
    foreach (bits[j]) begin
      exp.push_back({1'b1, bits[j], 1'b0});
      ones = bits[j] ? ones + 1 : 0;
      if (ones == 6) begin
        exp.push_back(3'b100);
        ones = 0;
      end
    end
    for (int k = 0; k < EOP_SE0_BITS; k++) exp.push_back(3'b101);
    exp.push_back(3'b110);
    if (is_desc) bus.descByte = pay[0];

    for (int i = 0; i < exp.size(); i++) begin
      tick();
      act  = outs();
      expv = {exp[i], !is_desc, is_desc, 2'b00};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s tick %0d: got %b want %b (oe,data,eop,gA,gD,dA,dD)", name, i, act, expv);
      end
      if (bus.descRd === 1'b1) begin
        rd++;
        idx++;
        bus.descByte = (idx < nb) ? pay[idx] : 8'($urandom);
      end
      if (i == 0 && drop) drop_req(is_desc);
      if (i == freeze_at) begin
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (outs() !== expv) bad++;
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL %s freeze: %0d unstable clocks, last %b want %b", name, bad, outs(), expv);
        end
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({outs(), bus.descRd} !== 8'h00) begin
          errors++;
          $display("FAIL %s reset-abort: got %b want 00000000", name, {outs(), bus.descRd});
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    tick();
    act  = outs();
    expv = {5'b00000, !is_desc, is_desc};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s done: got %b want %b", name, act, expv);
    end
    drop_req(is_desc);
    checks++;
    if (rd != nb) begin
      errors++;
      $display("FAIL %s descRd count: got %0d want %0d", name, rd, nb);
    end
  endtask

  task automatic check_gap(input string name);
    for (int g = 0; g < GAP_BITS; g++) begin
      tick();
      checks++;
      if ({outs(), bus.descRd} !== 8'h00) begin
        errors++;
        $display("FAIL %s gap %0d: got %b want 00000000", name, g, {outs(), bus.descRd});
      end
    end
  endtask

  task automatic setup_desc(input logic [7:0] pid, input int len, output int nb);
    bus.descPid = pid;
    bus.descLen = 4'(len);
    nb = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < 16; i++) pay[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({outs(), bus.descRd} !== 8'h00) begin
      errors++;
      $display("FAIL reset: got %b want 00000000", {outs(), bus.descRd});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({outs(), bus.descRd} !== 8'h00) begin
      errors++;
      $display("FAIL idle_no_req: got %b want 00000000", {outs(), bus.descRd});
    end
  endtask

  task automatic test_ack();
    tick_gap = 3;
    bus.reqAck = 1'b1;
    run_pkt("ack", 1'b0, PID_ACK, 0, -1, -1, 1'b1);
    check_gap("ack");
  endtask

  task automatic test_desc_empty();
    int nb;
    tick_gap = 1;
    setup_desc(PID_DATA0, 0, nb);
    bus.reqDesc = 1'b1;
    run_pkt("desc_empty", 1'b1, PID_DATA0, nb, -1, -1, 1'b1);
    check_gap("desc_empty");
  endtask

  task automatic test_stuff();
    int nb;
    tick_gap = 0;
    setup_desc(PID_DATA1, 1, nb);
    pay[0] = 8'hFF;
    bus.reqDesc = 1'b1;
    run_pkt("stuff", 1'b1, PID_DATA1, nb, -1, -1, 1'b0);
    check_gap("stuff");
  endtask

  task automatic test_clamp();
    int nb;
    tick_gap = 0;
    setup_desc(PID_DATA0, 15, nb);
    bus.reqDesc = 1'b1;
    run_pkt("clamp", 1'b1, PID_DATA0, nb, -1, -1, 1'b1);
    check_gap("clamp");
  endtask

  task automatic test_back_to_back();
    int nb;
    tick_gap = 2;
    setup_desc(PID_DATA1, 3, nb);
    bus.reqAck  = 1'b1;
    bus.reqDesc = 1'b1;
    run_pkt("prio_ack", 1'b0, PID_ACK, 0, -1, -1, 1'b0);
    check_gap("prio_gap");
    run_pkt("prio_desc", 1'b1, PID_DATA1, nb, -1, -1, 1'b1);
    check_gap("prio_desc");
  endtask

  task automatic test_reset_mid();
    int nb;
    tick_gap = 1;
    setup_desc(PID_DATA0, 4, nb);
    bus.reqDesc = 1'b1;
    run_pkt("rst_mid", 1'b1, PID_DATA0, nb, -1, 20, 1'b0);
    run_pkt("rst_restart", 1'b1, PID_DATA0, nb, -1, -1, 1'b0);
    check_gap("rst_restart");
  endtask

  task automatic test_freeze();
    int nb;
    tick_gap = 0;
    setup_desc(PID_DATA1, 2, nb);
    bus.reqDesc = 1'b1;
    run_pkt("freeze", 1'b1, PID_DATA1, nb, 11, -1, 1'b1);
    check_gap("freeze");
  endtask

  task automatic test_random();
    int nb;
    int choice;
    for (int n = 0; n < 20; n++) begin
      tick_gap = $urandom_range(0, 3);
      setup_desc(8'($urandom), $urandom_range(0, 15), nb);
      choice = $urandom_range(0, 2);
      if (choice != 1) bus.reqAck  = 1'b1;
      if (choice != 0) bus.reqDesc = 1'b1;
      if (choice != 1) begin
        run_pkt("rnd_ack", 1'b0, PID_ACK, 0, -1, -1, 1'($urandom_range(0, 1)));
        check_gap("rnd_ack");
      end
      if (choice != 0) begin
        run_pkt("rnd_desc", 1'b1, bus.descPid, nb, -1, -1, 1'($urandom_range(0, 1)));
        check_gap("rnd_desc");
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.bitTick  = 1'b0;
    bus.reqAck   = 1'b0;
    bus.reqDesc  = 1'b0;
    bus.descPid  = 8'h00;
    bus.descLen  = 4'h0;
    bus.descByte = 8'h00;
    test_reset();
    test_ack();
    test_desc_empty();
    test_stuff();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
